// File: rtl/pianoshield_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pianoshield_pkg
// Description : Shared definitions for the piano shield melody path. Contains
//               the song ROM word layout, the rest and end-of-song note codes,
//               the sequencer state encoding and helpers that pack and slice
//               ROM words at the default field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package pianoshield_pkg;

  // Default ROM geometry: {note[4:0], dur[2:0]} words, 32 entries.
  localparam int ROM_ADDR_W = 5;
  localparam int ROM_NOTE_W = 5;
  localparam int ROM_DUR_W  = 3;
  localparam int ROM_WORD_W = ROM_NOTE_W + ROM_DUR_W;

  localparam logic [ROM_NOTE_W-1:0] NOTE_REST = '0;
  localparam logic [ROM_NOTE_W-1:0] NOTE_END  = '1;

  // 3-bit binary state encoding, IDLE is the all-zero reset state.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_GAP   = 3'd4
  } seq_state_t;

  function automatic logic [ROM_NOTE_W-1:0] rom_note(input logic [ROM_WORD_W-1:0] word);
    return word[ROM_WORD_W-1 -: ROM_NOTE_W];
  endfunction

  function automatic logic [ROM_DUR_W-1:0] rom_dur(input logic [ROM_WORD_W-1:0] word);
    return word[ROM_DUR_W-1:0];
  endfunction

  function automatic logic [ROM_WORD_W-1:0] rom_word(input logic [ROM_NOTE_W-1:0] note,
                                                     input logic [ROM_DUR_W-1:0]  dur);
    return {note, dur};
  endfunction

endpackage
`default_nettype wire

// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : melody_sequencer
// Description : Steps through a song held in an external synchronous ROM
//               (1-cycle read latency). Each entry is a note code plus a
//               duration in beats; beats are counted from the beat_tick pulse
//               while a note plays, then a fixed silent gap separates notes.
//               Supports play/stop (stop resets to entry 0) and looping.
// Ports       : clk_in     - system clock
//               rst_in     - asynchronous reset, active-high
//               beat_tick  - one-cycle beat pulse
//               play_in    - level, 1 = play, 0 = stop
//               loop_en    - restart at entry 0 after the end of the song
//               rom_addr   - ROM address (data returns one cycle later)
//               rom_data   - ROM word {note, dur}
//               note_code  - current note code, 0 when silent
//               note_valid - tone generator enable
//               playing    - high in every state except IDLE
//               song_done  - one-cycle pulse when a non-looping song ends
// Revision    : 1.0 - initial release
// ============================================================================
module melody_sequencer
  import pianoshield_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int NOTE_W  = 5,
  parameter int DUR_W   = 3,
  parameter int GAP_CYC = 250000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    beat_tick,
  input  logic                    play_in,
  input  logic                    loop_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [NOTE_W+DUR_W-1:0] rom_data,
  output logic [NOTE_W-1:0]       note_code,
  output logic                    note_valid,
  output logic                    playing,
  output logic                    song_done
);

  localparam int BEATS_W = DUR_W + 1;
  localparam int GAP_W   = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

  localparam logic [NOTE_W-1:0] REST_CODE = '0;
  localparam logic [NOTE_W-1:0] END_CODE  = '1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  seq_state_t         state, state_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [NOTE_W-1:0]  code_nxt;
  logic               valid_nxt;
  logic               playing_nxt;
  logic               done_nxt;
  logic [BEATS_W-1:0] beats_left, beats_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic               end_hit;

  logic [NOTE_W-1:0]  ld_note;
  logic [DUR_W-1:0]   ld_dur;

  assign ld_note = rom_data[NOTE_W+DUR_W-1 -: NOTE_W];
  assign ld_dur  = rom_data[DUR_W-1:0];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= ST_IDLE;
      rom_addr   <= '0;
      note_code  <= '0;
      note_valid <= 1'b0;
      playing    <= 1'b0;
      song_done  <= 1'b0;
      beats_left <= '0;
      gap_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      rom_addr   <= addr_nxt;
      note_code  <= code_nxt;
      note_valid <= valid_nxt;
      playing    <= playing_nxt;
      song_done  <= done_nxt;
      beats_left <= beats_nxt;
      gap_cnt    <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = rom_addr;
    code_nxt  = note_code;
    valid_nxt = note_valid;
    done_nxt  = 1'b0;
    beats_nxt = beats_left;
    gap_nxt   = gap_cnt;
    end_hit   = 1'b0;

    case (state)
      ST_IDLE: begin
        state_nxt = ST_FETCH;
        addr_nxt  = '0;
      end

      // Address is held here so the ROM word is ready in LOAD.
      ST_FETCH: state_nxt = ST_LOAD;

      ST_LOAD: begin
        if (ld_note == END_CODE) begin
          end_hit = 1'b1;
        end else begin
          code_nxt  = ld_note;
          valid_nxt = (ld_note != REST_CODE);
          beats_nxt = BEATS_W'(ld_dur) + BEATS_W'(1);
          state_nxt = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (beat_tick) begin
          if (beats_left <= BEATS_W'(1)) begin
            state_nxt = ST_GAP;
            valid_nxt = 1'b0;
            beats_nxt = '0;
            gap_nxt   = GAP_W'(GAP_CYC - 1);
          end else begin
            beats_nxt = beats_left - BEATS_W'(1);
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt == '0) begin
          // Running off the last address ends the song like an END entry.
          if (rom_addr == ADDR_LAST) begin
            end_hit = 1'b1;
          end else begin
            addr_nxt  = rom_addr + ADDR_W'(1);
            state_nxt = ST_FETCH;
          end
        end else begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    if (end_hit) begin
      valid_nxt = 1'b0;
      beats_nxt = '0;
      gap_nxt   = '0;
      addr_nxt  = '0;
      if (loop_en) begin
        state_nxt = ST_FETCH;
      end else begin
        state_nxt = ST_IDLE;
        code_nxt  = '0;
        done_nxt  = 1'b1;
      end
    end

    // Stop overrides everything, including a song_done decision.
    if (!play_in) begin
      state_nxt = ST_IDLE;
      addr_nxt  = '0;
      code_nxt  = '0;
      valid_nxt = 1'b0;
      done_nxt  = 1'b0;
      beats_nxt = '0;
      gap_nxt   = '0;
    end

    playing_nxt = (state_nxt != ST_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_melody_sequencer
// Description : Directed self-checking bench for melody_sequencer with a
//               1-cycle-latency ROM model, a beat generator and a scoreboard
//               of expected notes (code, address, beats counted while valid).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_melody_sequencer;
  import pianoshield_pkg::*;

  localparam int GAP_CYC  = 4;
  localparam int TICK_PER = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       beat_tick;
  logic       play_in;
  logic       loop_en;
  logic [4:0] rom_addr;
  logic [7:0] rom_data;
  logic [4:0] note_code;
  logic       note_valid;
  logic       playing;
  logic       song_done;

  logic [7:0] rom [0:31];

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  melody_sequencer #(
    .ADDR_W (5),
    .NOTE_W (5),
    .DUR_W  (3),
    .GAP_CYC(GAP_CYC)
  ) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .beat_tick (beat_tick),
    .play_in   (play_in),
    .loop_en   (loop_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note_code (note_code),
    .note_valid(note_valid),
    .playing   (playing),
    .song_done (song_done)
  );

  typedef struct {
    logic [4:0] note;
    logic [4:0] addr;
    int         beats;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  bit   dense       = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and stop at the falling edge. Beats arrive every
  // TICK_PER cycles; in dense mode a tick is also offered on every cycle in
  // which no note is sounding, so FETCH/LOAD/GAP see ticks too.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    beat_tick = ((cyc % TICK_PER) == 0) || (dense && !note_valid);
  endtask

  task automatic fill_end();
    for (int i = 0; i < 32; i++) rom[i] = rom_word(NOTE_END, 3'd0);
  endtask

  // Watch the outputs, checking each sounding note against the scoreboard.
  task automatic run(input bit want_done, input int budget,
                     output int done_cnt, output int fall_to_done);
    bit   prev_valid;
    int   fall_cyc;
    int   n;
    int   ticks;
    bit   timed_out;
    exp_t item;
    prev_valid   = note_valid;
    fall_cyc     = -1;
    done_cnt     = 0;
    fall_to_done = -1;
    n            = 0;
    ticks        = 0;
    timed_out    = 1'b0;
    while (1) begin
      if (beat_tick && note_valid) ticks++;
      step();
      n++;
      if (note_valid && !prev_valid) begin
        check("note_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("note_code", note_code, exp_q[0].note);
          check("note_addr", rom_addr, exp_q[0].addr);
        end
        ticks = 0;
      end
      if (!note_valid && prev_valid) begin
        check("fall_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          item = exp_q.pop_front();
          check("note_beats", ticks, item.beats);
        end
        fall_cyc = n;
      end
      if (song_done) begin
        done_cnt++;
        if (fall_cyc >= 0) fall_to_done = n - fall_cyc;
        if (want_done) begin
          play_in = 1'b0;
          break;
        end
      end
      prev_valid = note_valid;
      if (!want_done && exp_q.size() == 0) break;
      if (n >= budget) begin
        timed_out = 1'b1;
        break;
      end
    end
    check("run_timeout", timed_out, 0);
  endtask

  initial begin
    int d;
    int f;
    int k;
    int t;
    int extra;

    rst       = 1'b1;
    play_in   = 1'b0;
    loop_en   = 1'b0;
    beat_tick = 1'b0;
    fill_end();
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_rom_addr",   rom_addr,   0);
    check("rst_note_code",  note_code,  0);
    check("rst_note_valid", note_valid, 0);
    check("rst_playing",    playing,    0);
    check("rst_song_done",  song_done,  0);
    rst = 1'b0;
    step();
    step();
    check("idle_playing", playing, 0);

    // Test 1: single note, no loop, latency, gap length and song_done
    fill_end();
    rom[0]  = rom_word(5'd12, 3'd1);
    loop_en = 1'b0;
    dense   = 1'b0;
    play_in = 1'b1;
    step();
    step();
    check("t1_valid_cyc2", note_valid, 0);
    step();
    check("t1_valid_cyc3", note_valid, 1);
    check("t1_code_cyc3",  note_code,  12);
    check("t1_playing",    playing,    1);
    exp_q.push_back('{note: 5'd12, addr: 5'd0, beats: 2});
    run(1'b1, 400, d, f);
    check("t1_done_cnt",      d,            1);
    check("t1_fall_to_done",  f,            6);
    check("t1_playing_done",  playing,      0);
    check("t1_queue_empty",   exp_q.size(), 0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (song_done) extra++;
    end
    check("t1_single_pulse", extra,   0);
    check("t1_idle_playing", playing, 0);

    // Test 2: rest entry then E4, dense ticks make the rest one cycle of PLAY
    fill_end();
    rom[0]  = rom_word(5'd0,  3'd0);
    rom[1]  = rom_word(5'd16, 3'd0);
    dense   = 1'b1;
    play_in = 1'b1;
    for (k = 1; k <= 40; k++) begin
      step();
      if (note_valid) break;
    end
    check("t2_first_valid_cyc", k,         10);
    check("t2_first_code",      note_code, 16);
    exp_q.push_back('{note: 5'd16, addr: 5'd1, beats: 1});
    run(1'b1, 400, d, f);
    check("t2_done_cnt", d, 1);
    step();
    step();

    // Test 3: looping, three passes of the single-note song
    fill_end();
    rom[0]  = rom_word(5'd12, 3'd1);
    dense   = 1'b0;
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back('{note: 5'd12, addr: 5'd0, beats: 2});
    play_in = 1'b1;
    run(1'b0, 2000, d, f);
    check("t3_no_done", d, 0);
    play_in = 1'b0;
    step();
    check("t3_stop_playing", playing, 0);
    loop_en = 1'b0;

    // Test 4: stop in the middle of a 4-beat note, then restart from entry 0
    fill_end();
    rom[0]  = rom_word(5'd3, 3'd0);
    rom[1]  = rom_word(5'd7, 3'd3);
    play_in = 1'b1;
    for (k = 0; k < 200; k++) begin
      if (note_valid && note_code == 5'd7) break;
      step();
    end
    check("t4_second_note", note_code, 7);
    t = 0;
    for (k = 0; k < 200 && t < 2; k++) begin
      if (beat_tick && note_valid) t++;
      step();
    end
    check("t4_mid_note", note_valid, 1);
    check("t4_mid_addr", rom_addr,   1);
    play_in = 1'b0;
    step();
    check("t4_stop_valid",   note_valid, 0);
    check("t4_stop_code",    note_code,  0);
    check("t4_stop_addr",    rom_addr,   0);
    check("t4_stop_playing", playing,    0);
    check("t4_stop_done",    song_done,  0);
    step();
    step();
    play_in = 1'b1;
    step();
    step();
    step();
    check("t4_restart_valid", note_valid, 1);
    check("t4_restart_code",  note_code,  3);
    check("t4_restart_addr",  rom_addr,   0);
    play_in = 1'b0;
    step();
    step();

    // Test 5: full 32-entry song without an END entry, address wrap ends it
    for (int i = 0; i < 32; i++) begin
      rom[i] = rom_word(5'((i % 30) + 1), 3'd0);
      exp_q.push_back('{note: 5'((i % 30) + 1), addr: 5'(i), beats: 1});
    end
    dense   = 1'b1;
    play_in = 1'b1;
    run(1'b1, 3000, d, f);
    check("t5_done_cnt",     d,            1);
    check("t5_wrap_gap",     f,            4);
    check("t5_queue_empty",  exp_q.size(), 0);
    step();
    step();

    // Test 6: ticks during FETCH/LOAD/GAP must not shorten notes
    fill_end();
    rom[0] = rom_word(5'd9, 3'd2);
    rom[1] = rom_word(5'd3, 3'd1);
    exp_q.push_back('{note: 5'd9, addr: 5'd0, beats: 3});
    exp_q.push_back('{note: 5'd3, addr: 5'd1, beats: 2});
    play_in = 1'b1;
    run(1'b1, 600, d, f);
    check("t6_done_cnt", d, 1);
    step();
    step();

    // Asynchronous reset in the middle of a note
    play_in = 1'b1;
    for (k = 0; k < 20; k++) begin
      if (note_valid) break;
      step();
    end
    check("t6_rst_pre_valid", note_valid, 1);
    step();
    step();
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid",   note_valid, 0);
    check("t6_rst_code",    note_code,  0);
    check("t6_rst_playing", playing,    0);
    check("t6_rst_addr",    rom_addr,   0);
    play_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    check("t6_post_rst_playing", playing, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
